// File: rtl/turing_pkg.sv
// Shared definitions for the unary-addition tape machine: loader states,
// cell symbols and the default tape length.
package turing_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        RUN_A = 3'd2,
        SEP   = 3'd3,
        RUN_B = 3'd4,
        PAD   = 3'd5,
        DONE  = 3'd6
    } loader_state_e;

    localparam logic CELL_BLANK = 1'b0;
    localparam logic CELL_MARK  = 1'b1;

    localparam int TAPE_W_DEFAULT = 10;

endpackage

// File: rtl/unary_tape_loader.sv
// Serially builds the unary tape image of an operand pair, one cell per clock.
// Optional macro UNARY_TAPE_SUM_EN adds the tape_sum output (op_a+op_b).
module unary_tape_loader
    import turing_pkg::*;
#(
    parameter int TAPE_W = TAPE_W_DEFAULT,
    parameter int OP_W   = 4,
    localparam int SUM_W = $clog2(TAPE_W + 1),
    localparam int POS_W = $clog2(TAPE_W)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic [TAPE_W-1:0] tape,
    output logic              tape_valid,
    input  logic              tape_ack,
    output logic              ovf
`ifdef UNARY_TAPE_SUM_EN
    ,
    output logic [SUM_W-1:0]  tape_sum
`endif
);

    localparam logic [OP_W:0]    MAX_SUM  = (OP_W + 1)'(TAPE_W - 2);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(TAPE_W - 1);

    loader_state_e     state_r;
    logic [POS_W-1:0]  pos_r;
    logic [OP_W-1:0]   rem_a_r;
    logic [OP_W-1:0]   rem_b_r;
    logic [TAPE_W-1:0] tape_r;
    logic              tape_valid_r;
    logic              op_ready_r;
    logic              ovf_r;
    logic [OP_W:0]     sum_s;
    logic              fits_s;

    // Operand sum one bit wider than the operands so it cannot wrap.
    always_comb begin
        sum_s  = {1'b0, op_a} + {1'b0, op_b};
        fits_s = (sum_s <= MAX_SUM);
    end

`ifdef UNARY_TAPE_SUM_EN
    logic [SUM_W-1:0] sum_r;

    // Expected count of marks, captured when a legal pair is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_r <= {SUM_W{1'b0}};
        end else if (state_r == IDLE && op_ready_r && op_valid && fits_s) begin
            sum_r <= SUM_W'(sum_s);
        end else begin
            sum_r <= sum_r;
        end
    end

    assign tape_sum = sum_r;
`endif

    // Loader FSM: accept/reject, one cell write per build state, hold in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            pos_r        <= {POS_W{1'b0}};
            rem_a_r      <= {OP_W{1'b0}};
            rem_b_r      <= {OP_W{1'b0}};
            tape_r       <= {TAPE_W{1'b0}};
            tape_valid_r <= 1'b0;
            op_ready_r   <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            ovf_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!op_ready_r) begin
                        op_ready_r <= 1'b1;
                    end else if (op_valid && fits_s) begin
                        rem_a_r    <= op_a;
                        rem_b_r    <= op_b;
                        tape_r     <= {TAPE_W{1'b0}};
                        pos_r      <= {POS_W{1'b0}};
                        op_ready_r <= 1'b0;
                        state_r    <= LEAD;
                    end else if (op_valid) begin
                        ovf_r <= 1'b1;
                    end
                end
                LEAD: begin
                    tape_r[pos_r] <= CELL_BLANK;
                    pos_r         <= pos_r + POS_W'(1);
                    state_r       <= (rem_a_r != {OP_W{1'b0}}) ? RUN_A : SEP;
                end
                RUN_A: begin
                    tape_r[pos_r] <= CELL_MARK;
                    pos_r         <= pos_r + POS_W'(1);
                    rem_a_r       <= rem_a_r - OP_W'(1);
                    if (rem_a_r == OP_W'(1)) begin
                        state_r <= SEP;
                    end
                end
                SEP: begin
                    tape_r[pos_r] <= CELL_BLANK;
                    pos_r         <= pos_r + POS_W'(1);
                    if (pos_r == LAST_POS) begin
                        state_r      <= DONE;
                        tape_valid_r <= 1'b1;
                    end else if (rem_b_r != {OP_W{1'b0}}) begin
                        state_r <= RUN_B;
                    end else begin
                        state_r <= PAD;
                    end
                end
                RUN_B: begin
                    tape_r[pos_r] <= CELL_MARK;
                    pos_r         <= pos_r + POS_W'(1);
                    rem_b_r       <= rem_b_r - OP_W'(1);
                    if (pos_r == LAST_POS) begin
                        state_r      <= DONE;
                        tape_valid_r <= 1'b1;
                    end else if (rem_b_r == OP_W'(1)) begin
                        state_r <= PAD;
                    end
                end
                PAD: begin
                    tape_r[pos_r] <= CELL_BLANK;
                    pos_r         <= pos_r + POS_W'(1);
                    if (pos_r == LAST_POS) begin
                        state_r      <= DONE;
                        tape_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (tape_ack) begin
                        tape_valid_r <= 1'b0;
                        op_ready_r   <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    tape_valid_r <= 1'b0;
                    op_ready_r   <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready   = op_ready_r;
    assign tape       = tape_r;
    assign tape_valid = tape_valid_r;
    assign ovf        = ovf_r;

endmodule
